// File: rtl/mp_isa_pkg.sv
// Shared ISA constants and loader state encoding
// for the 8-bit core's program memory.
package mp_isa_pkg;

    localparam logic [1:0] OPC_ADD  = 2'b00;
    localparam logic [1:0] OPC_LW   = 2'b01;
    localparam logic [1:0] OPC_SW   = 2'b10;
    localparam logic [1:0] OPC_BR   = 2'b11;

    // Branch +0: PC advances by one, nothing written
    localparam logic [7:0] NOP_WORD = 8'hC0;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/prog_ram.sv
// Program store: DEPTH x 8, one synchronous write port,
// one synchronous read port, contents never reset.
module prog_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    // Write the loaded byte and register the fetched word
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/program_memory.sv
// Instruction-side responder: byte-stream program loader plus fetch port.
// Optional parity checking of load beats is built when PROG_PARITY_EN is defined.
module program_memory #(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  NOP_WORD = mp_isa_pkg::NOP_WORD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [7:0]        instruction,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
`ifdef PROG_PARITY_EN
    input  logic              load_parity,
`endif
    output logic              load_ready,
    input  logic              reload,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   prog_len,
    output logic              load_error
);

    import mp_isa_pkg::state_t;
    import mp_isa_pkg::ST_LOAD;
    import mp_isa_pkg::ST_RUN;

    localparam int RAM_AW = $clog2(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W:0]     r_len;
    logic                r_hold;
    logic                r_rd_ok;
    logic                w_err;
    logic                w_ready;
    logic                w_accept;
    logic                w_par_bad;
    logic                w_full;
    logic                w_fetch_ok;
    logic [7:0]          w_rdata;

`ifdef PROG_PARITY_EN
    logic                r_err;

    assign w_par_bad = ^{load_data, load_parity};
    assign w_err     = r_err;

    // Sticky parity error, cleared by reset or reload
    always_ff @(posedge clock) begin
        if (reset || reload) begin
            r_err <= 1'b0;
        end else if (w_accept && w_par_bad) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_par_bad = 1'b0;
    assign w_err     = 1'b0;
`endif

    assign w_full = (r_wptr == ADDR_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: finish on last beat, full store, or bare load_last
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_LOAD: begin
                if (reload) begin
                    w_next = ST_LOAD;
                end else if (w_accept && !w_par_bad &&
                             (load_last || w_full)) begin
                    w_next = ST_RUN;
                end else if (!load_valid && load_last && !w_err) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    w_next = ST_LOAD;
                end
            end
            default: w_next = ST_LOAD;
        endcase
    end

    // Loader handshake; reload outranks any beat
    always_comb begin
        w_ready  = (r_state == ST_LOAD) && !w_err;
        w_accept = load_valid && w_ready && !reload;
    end

    // Write pointer and loaded-length counters
    always_ff @(posedge clock) begin
        if (reset || reload) begin
            r_wptr <= '0;
            r_len  <= '0;
        end else if (w_accept) begin
            r_wptr <= r_wptr + 1'b1;
            r_len  <= r_len + 1'b1;
        end
    end

    // Core hold follows the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold <= 1'b1;
        end else begin
            r_hold <= (w_next == ST_LOAD);
        end
    end

    // Old prog_len decides validity, so a word being written reads as NOP
    assign w_fetch_ok = ({1'b0, fetch_addr} < r_len) &&
                        ({1'b0, fetch_addr} < (ADDR_W+1)'(DEPTH));

    // Register the fetch-valid flag alongside the RAM read
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ok <= 1'b0;
        end else begin
            r_rd_ok <= w_fetch_ok;
        end
    end

    prog_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_accept),
        .i_waddr (r_wptr[RAM_AW-1:0]),
        .i_wdata (load_data),
        .i_raddr (fetch_addr[RAM_AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign instruction = r_rd_ok ? w_rdata : NOP_WORD;
    assign load_ready  = w_ready;
    assign cpu_hold    = r_hold;
    assign prog_len    = r_len;
    assign load_error  = w_err;

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory (default build, no parity).
// Fetch results are checked through an expected-value queue.
module tb_program_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] fetch_addr;
    logic [7:0] instruction;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       reload;
    logic       cpu_hold;
    logic [8:0] prog_len;
    logic       load_error;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } fetch_vec_t;

    fetch_vec_t vecs [6];

    program_memory dut (
        .clock       (clk),
        .reset       (reset),
        .fetch_addr  (fetch_addr),
        .instruction (instruction),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .reload      (reload),
        .cpu_hold    (cpu_hold),
        .prog_len    (prog_len),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present an address, queue its expected word, compare after the edge
    task automatic fetch(input logic [7:0] a, input logic [7:0] e);
        logic [7:0] x;
        fetch_addr = a;
        exp_q.push_back(e);
        tick();
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard empty for addr %0h", a);
        end else begin
            x = exp_q.pop_front();
            chk($sformatf("fetch[%0h]", a), int'(instruction), int'(x));
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h05};
        vecs[1] = '{8'h01, 8'h4A};
        vecs[2] = '{8'h02, 8'h83};
        vecs[3] = '{8'h03, 8'hC0};
        vecs[4] = '{8'hFF, 8'hC0};
        vecs[5] = '{8'h01, 8'h4A};

        reset      = 1'b1;
        fetch_addr = '0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        reload     = 1'b0;
        tick();
        tick();
        chk("rst_instr", int'(instruction), 8'hC0);
        chk("rst_hold", int'(cpu_hold), 1);
        chk("rst_ready", int'(load_ready), 1);
        chk("rst_len", int'(prog_len), 0);
        chk("rst_err", int'(load_error), 0);
        reset = 1'b0;

        // Three-byte program, last on third
        beat(8'h05, 1'b0);
        beat(8'h4A, 1'b0);
        chk("ld2_hold", int'(cpu_hold), 1);
        beat(8'h83, 1'b1);
        chk("ld3_hold", int'(cpu_hold), 0);
        chk("ld3_ready", int'(load_ready), 0);
        chk("ld3_len", int'(prog_len), 3);

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].addr, vecs[i].exp);
        end

        // Loader activity ignored in RUN
        beat(8'h11, 1'b1);
        chk("run_ign_len", int'(prog_len), 3);
        fetch(8'h00, 8'h05);

        // Reload with a valid beat alongside: no write
        load_valid = 1'b1;
        load_data  = 8'h99;
        do_reload();
        load_valid = 1'b0;
        chk("rl_hold", int'(cpu_hold), 1);
        chk("rl_len", int'(prog_len), 0);
        chk("rl_ready", int'(load_ready), 1);
        fetch(8'h00, 8'hC0);

        // Word written the same cycle it is fetched reads as NOP
        fetch_addr = 8'h00;
        exp_q.push_back(8'hC0);
        beat(8'h44, 1'b0);
        chk("rdw", int'(instruction), int'(exp_q.pop_front()));
        fetch(8'h00, 8'h44);
        chk("rdw_hold", int'(cpu_hold), 1);

        // Fill entire store without load_last
        do_reload();
        for (int i = 0; i < 255; i++) begin
            beat(8'(i) ^ 8'h5A, 1'b0);
        end
        chk("full254_ready", int'(load_ready), 1);
        chk("full254_len", int'(prog_len), 255);
        beat(8'hFF ^ 8'h5A, 1'b0);
        chk("full_ready", int'(load_ready), 0);
        chk("full_hold", int'(cpu_hold), 0);
        chk("full_len", int'(prog_len), 256);
        beat(8'h77, 1'b0);
        chk("full_nowrap", int'(prog_len), 256);
        fetch(8'hFF, 8'hA5);
        fetch(8'h80, 8'hDA);
        fetch(8'h00, 8'h5A);

        // Reset after 2 of 5 beats discards partial program
        do_reload();
        beat(8'h21, 1'b0);
        beat(8'h22, 1'b0);
        chk("mid_len", int'(prog_len), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_len", int'(prog_len), 0);
        chk("mid_rst_hold", int'(cpu_hold), 1);
        fetch(8'h00, 8'hC0);
        beat(8'h33, 1'b1);
        chk("mid_len1", int'(prog_len), 1);
        chk("mid_run", int'(cpu_hold), 0);
        fetch(8'h00, 8'h33);
        fetch(8'h01, 8'hC0);

        // Bare load_last gives an empty program
        do_reload();
        load_last = 1'b1;
        tick();
        load_last = 1'b0;
        chk("empty_hold", int'(cpu_hold), 0);
        chk("empty_len", int'(prog_len), 0);
        fetch(8'h00, 8'hC0);

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard leftover %0d", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
